// File: rtl/mem_bridge_pkg.sv
// ==================================================================
// mem_bridge_pkg : shared types and constants for the SRAM bridge
// Rev 1.0
// ==================================================================
`default_nettype none

package mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_DONE  = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5,
        IO_DONE  = 3'd6
    } state_t;

    localparam logic [19:0] IO_ADDR_DEFAULT = 20'hFFFFF;

    typedef logic [3:0] wait_cnt_t;

    // Active-low byte enables: a disabled byte keeps its old value.
    function automatic logic [15:0] byte_merge(input logic [15:0] old_val,
                                               input logic [15:0] new_val,
                                               input logic        ub_n,
                                               input logic        lb_n);
        byte_merge[15:8] = ub_n ? old_val[15:8] : new_val[15:8];
        byte_merge[7:0]  = lb_n ? old_val[7:0]  : new_val[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bridge_sync_2ff.sv
// ==================================================================
// sync_2ff : two-flop synchronizer for asynchronous level inputs
// Rev 1.0
// ==================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_bridge.sv
// ==================================================================
// mem_bridge : LC-3 memory strobes to async 16-bit SRAM, plus one I/O word
// Rev 1.0
// ==================================================================
`default_nettype none

module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int          READ_WAIT   = 2,
    parameter int          WRITE_PULSE = 2,
    parameter logic [19:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [19:0] MAR,
    input  logic [15:0] Data_from_CPU,
    input  logic        Mem_CE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic        Mem_Ready,
    output logic [15:0] HEX_Data,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam wait_cnt_t READ_CNT_INIT  = wait_cnt_t'(READ_WAIT - 1);
    localparam wait_cnt_t WRITE_CNT_INIT = wait_cnt_t'(WRITE_PULSE - 1);

    state_t      state;
    state_t      state_nxt;
    logic        armed;
    wait_cnt_t   wait_cnt;
    logic [15:0] lat_data;
    logic        lat_ub_n;
    logic        lat_lb_n;
    logic        drive_dq;
    logic [15:0] switches_sync;

    logic request;
    logic req_write;
    logic io_hit;

    sync_2ff #(
        .WIDTH (16)
    ) u_sw_sync (
        .clk   (Clk),
        .rst_n (Reset_n),
        .d     (Switches),
        .q     (switches_sync)
    );

    assign request   = (state == IDLE) && armed && !Mem_CE && (!Mem_WE || !Mem_OE);
    assign req_write = !Mem_WE;
    assign io_hit    = (MAR == IO_ADDR);

    assign SRAM_DQ = drive_dq ? lat_data : 16'bz;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            armed       <= 1'b1;
            wait_cnt    <= '0;
            SRAM_ADDR   <= '0;
            lat_data    <= '0;
            lat_ub_n    <= 1'b1;
            lat_lb_n    <= 1'b1;
            Data_to_CPU <= '0;
            HEX_Data    <= '0;
        end else begin
            state <= state_nxt;
            if (request) begin
                armed     <= 1'b0;
                SRAM_ADDR <= MAR;
                lat_data  <= Data_from_CPU;
                lat_ub_n  <= Mem_UB;
                lat_lb_n  <= Mem_LB;
                wait_cnt  <= READ_CNT_INIT;
                if (io_hit && req_write)
                    HEX_Data <= byte_merge(HEX_Data, Data_from_CPU, Mem_UB, Mem_LB);
                else if (io_hit)
                    Data_to_CPU <= switches_sync;
            end else if (state == IDLE && Mem_OE && Mem_WE) begin
                // Only a fully released strobe pair lets the next access start.
                armed <= 1'b1;
            end

            if (state == RD_WAIT) begin
                if (wait_cnt == '0)
                    Data_to_CPU <= SRAM_DQ;
                else
                    wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == WR_SETUP)
                wait_cnt <= WRITE_CNT_INIT;
            if (state == WR_PULSE && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        drive_dq  = 1'b0;
        Mem_Ready = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (io_hit)
                        state_nxt = IO_DONE;
                    else if (req_write)
                        state_nxt = WR_SETUP;
                    else
                        state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = lat_ub_n;
                SRAM_LB_N = lat_lb_n;
                if (wait_cnt == '0)
                    state_nxt = RD_DONE;
            end
            RD_DONE: begin
                Mem_Ready = 1'b1;
                state_nxt = IDLE;
            end
            WR_SETUP: begin
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = lat_ub_n;
                SRAM_LB_N = lat_lb_n;
                drive_dq  = 1'b1;
                state_nxt = WR_PULSE;
            end
            WR_PULSE: begin
                SRAM_CE_N = 1'b0;
                SRAM_WE_N = 1'b0;
                SRAM_UB_N = lat_ub_n;
                SRAM_LB_N = lat_lb_n;
                drive_dq  = 1'b1;
                if (wait_cnt == '0)
                    state_nxt = WR_HOLD;
            end
            WR_HOLD: begin
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = lat_ub_n;
                SRAM_LB_N = lat_lb_n;
                drive_dq  = 1'b1;
                Mem_Ready = 1'b1;
                state_nxt = IDLE;
            end
            IO_DONE: begin
                Mem_Ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bridge.sv
// ==================================================================
// tb_mem_bridge : scoreboard bench for mem_bridge with a small SRAM model
// Rev 1.0
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_bridge;

    localparam logic [1:0] K_RD  = 2'd0;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_HEX = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] mar = '0;
    logic [15:0] wdata = '0;
    logic        ce = 1'b1, ub = 1'b1, lb = 1'b1, oe = 1'b1, we = 1'b1;
    logic [15:0] switches = '0;

    logic [15:0] data_to_cpu, hex_data;
    logic        mem_ready;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int   total = 0;
    int   passed = 0;
    int   oe_low = 0;
    int   we_low = 0;
    int   ready_seen = 0;
    exp_t sb_q[$];
    logic [15:0] exp_hold = '0;
    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    mem_bridge #(
        .READ_WAIT   (2),
        .WRITE_PULSE (2),
        .IO_ADDR     (20'hFFFFF)
    ) dut (
        .Clk           (clk),
        .Reset_n       (rst_n),
        .MAR           (mar),
        .Data_from_CPU (wdata),
        .Mem_CE        (ce),
        .Mem_UB        (ub),
        .Mem_LB        (lb),
        .Mem_OE        (oe),
        .Mem_WE        (we),
        .Switches      (switches),
        .Data_to_CPU   (data_to_cpu),
        .Mem_Ready     (mem_ready),
        .HEX_Data      (hex_data),
        .SRAM_ADDR     (sram_addr),
        .SRAM_DQ       (sram_dq),
        .SRAM_CE_N     (sram_ce_n),
        .SRAM_OE_N     (sram_oe_n),
        .SRAM_WE_N     (sram_we_n),
        .SRAM_UB_N     (sram_ub_n),
        .SRAM_LB_N     (sram_lb_n)
    );

    // Asynchronous SRAM: drives on CE+OE, stores enabled bytes while WE is low.
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 16'bz;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h10] <= 16'hBEEF;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: strobe activity counters plus scoreboard pop on every ready pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            if (mem_ready) begin
                ready_seen++;
                if (sb_q.size() == 0) begin
                    check("ready_without_request", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    case (e.kind)
                        K_RD:    check("read_data", {16'h0, data_to_cpu}, {16'h0, e.data});
                        K_HEX:   check("hex_data", {16'h0, hex_data}, {16'h0, e.data});
                        default: check("write_keeps_rdata", {16'h0, data_to_cpu}, {16'h0, e.data});
                    endcase
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        ce = 1'b1; oe = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1;
    endtask

    // w/r select the strobes; u/l are the raw active-low byte enables.
    task automatic start(input logic [19:0] a, input logic [15:0] d,
                         input logic w, input logic r, input logic u, input logic l);
        mar = a; wdata = d; ce = 1'b0; we = ~w; oe = ~r; ub = u; lb = l;
    endtask

    task automatic access(input logic [19:0] a, input logic [15:0] d,
                          input logic w, input logic r, input logic u, input logic l,
                          input int hold);
        start(a, d, w, r, u, l);
        tick(hold);
        idle_bus();
        tick(5);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int o0, w0, r0;
        switches = 16'h00A5;
        idle_bus();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);

        // Reset and idle
        check("rst_strobes", {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("rst_hex", {16'h0, hex_data}, 32'h0);
        check("rst_rdata", {16'h0, data_to_cpu}, 32'h0);
        check("rst_addr", {12'h0, sram_addr}, 32'h0);
        check("rst_no_ready", ready_seen, 0);

        // SRAM read of 0xBEEF, strobe held 4 cycles
        o0 = oe_low; r0 = ready_seen;
        sb_q.push_back('{K_RD, 16'hBEEF}); exp_hold = 16'hBEEF;
        start(20'h00010, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        check("rd_c1", {29'h0, mem_ready, sram_oe_n, sram_ce_n}, 32'h0);
        tick(1);
        check("rd_c2", {29'h0, mem_ready, sram_oe_n, sram_ce_n}, 32'h0);
        tick(1);
        check("rd_c3_ready", {30'h0, mem_ready, sram_oe_n}, 32'h3);
        tick(1);
        idle_bus();
        tick(4);
        check("rd_oe_cycles", oe_low - o0, 2);
        check("rd_one_access", ready_seen - r0, 1);

        // SRAM write 0x1234, strobe withdrawn after one cycle
        w0 = we_low; r0 = ready_seen;
        sb_q.push_back('{K_WR, exp_hold});
        start(20'h00020, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        check("wr_setup", {15'h0, sram_ce_n, sram_we_n, sram_dq}, {15'h0, 1'b0, 1'b1, 16'h1234});
        idle_bus();
        tick(1);
        check("wr_pulse", {16'h0, sram_we_n, sram_dq[14:0]}, {16'h0, 1'b0, 15'h1234});
        tick(2);
        check("wr_hold", {14'h0, mem_ready, sram_we_n, sram_dq}, {14'h0, 1'b1, 1'b1, 16'h1234});
        tick(4);
        check("wr_we_cycles", we_low - w0, 2);
        check("wr_one_access", ready_seen - r0, 1);

        sb_q.push_back('{K_RD, 16'h1234}); exp_hold = 16'h1234;
        access(20'h00020, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4);

        // Byte write: upper byte disabled
        sb_q.push_back('{K_WR, exp_hold});
        access(20'h00020, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        tick(2);
        sb_q.push_back('{K_RD, 16'h12FF}); exp_hold = 16'h12FF;
        access(20'h00020, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4);

        // I/O read of the switches
        sb_q.push_back('{K_RD, 16'h00A5}); exp_hold = 16'h00A5;
        start(20'hFFFFF, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        check("io_rd", {12'h0, mem_ready, sram_ce_n, sram_oe_n, sram_we_n, data_to_cpu},
              {12'h0, 4'hF, 16'h00A5});
        idle_bus();
        tick(5);

        // I/O write with lower byte disabled
        sb_q.push_back('{K_HEX, 16'hC000});
        start(20'hFFFFF, 16'hC0DE, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        check("io_wr_no_sram", {29'h0, mem_ready, sram_ce_n, sram_we_n}, 32'h7);
        idle_bus();
        tick(5);
        check("io_hex_held", {16'h0, hex_data}, 32'hC000);

        // Both strobes low for 8 cycles: one write only, then re-arm
        o0 = oe_low; w0 = we_low; r0 = ready_seen;
        sb_q.push_back('{K_WR, exp_hold});
        start(20'h00030, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(8);
        check("simul_we_cycles", we_low - w0, 2);
        check("simul_no_read", oe_low - o0, 0);
        check("simul_one_access", ready_seen - r0, 1);
        idle_bus();
        tick(1);
        sb_q.push_back('{K_RD, 16'h5555}); exp_hold = 16'h5555;
        access(20'h00030, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        check("rearm_second_access", ready_seen - r0, 2);

        // Reset in the middle of a write pulse
        r0 = ready_seen;
        start(20'h00040, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(2);
        check("mid_wr_pulse", {31'h0, sram_we_n}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_strobes", {27'h0, mem_ready, sram_ce_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'hF);
        idle_bus();
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("rst_no_ready", ready_seen - r0, 0);
        check("rst_clears_regs", {hex_data, data_to_cpu}, 32'h0);
        exp_hold = 16'h0;
        sb_q.push_back('{K_RD, 16'hBEEF}); exp_hold = 16'hBEEF;
        access(20'h00010, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the LC-3 control unit and datapath, between the CPU-side memory strobes (Mem_CE/UB/LB/OE/WE, MAR, MDR) and the external asynchronous 16-bit SRAM.
- Converts each strobe-level request into a timed SRAM read or write cycle with a registered address and data-bus tristate control.
- Decodes one memory-mapped I/O address: reads return the board switches, and writes load the hex-display register.
- Returns read data to the MDR input and pulses a one-cycle ready indication on completion.

Parameters:
- READ_WAIT, 2: cycles SRAM_OE_N is held low before data capture (1..15).
- WRITE_PULSE, 2: cycles SRAM_WE_N is held low (1..15).
- IO_ADDR, 20'hFFFFF: address decoded as I/O (MAR compared over its full 20 bits).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- MAR  in  20  CPU address.
- Data_from_CPU  in  16  write data (MDR).
- Mem_CE  in  1  active-low chip enable from the control unit.
- Mem_UB  in  1  active-low upper byte enable.
- Mem_LB  in  1  active-low lower byte enable.
- Mem_OE  in  1  active-low read strobe.
- Mem_WE  in  1  active-low write strobe.
- Switches  in  16  asynchronous board switches.
- Data_to_CPU  out  16  read data to MDR mux.
- Mem_Ready  out  1  one-cycle completion pulse.
- HEX_Data  out  16  hex-display register.
- SRAM_ADDR  out  20  registered SRAM address.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_CE_N  out  1  SRAM chip enable, active low.
- SRAM_OE_N  out  1  SRAM output enable, active low.
- SRAM_WE_N  out  1  SRAM write enable, active low.
- SRAM_UB_N  out  1  SRAM upper byte enable, active low.
- SRAM_LB_N  out  1  SRAM lower byte enable, active low.

Behaviour:
- Clock and reset: one clock (Clk); reset (Reset_n) is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - Data_to_CPU = 0, HEX_Data = 0, Mem_Ready = 0, SRAM_ADDR = 0.
  - All SRAM_*_N = 1.
  - SRAM_DQ = Z.
  - armed = 1.
- Request detection: in IDLE with armed = 1 and Mem_CE = 0:
  - Mem_WE = 0 gives a write request.
  - Otherwise, Mem_OE = 0 gives a read request.
  - Write wins if both strobes are low.
- Latching: MAR, Data_from_CPU, UB and LB are latched on the request edge. Later CPU changes are ignored until the access returns to IDLE.
- Re-arm: armed clears at request. It sets again only after a cycle in IDLE with Mem_OE = 1 and Mem_WE = 1. This stops a strobe held over several control states from causing a second access.
- SRAM read path, IDLE -> RD_WAIT -> RD_DONE -> IDLE:
  - RD_WAIT: SRAM_CE_N = 0 and SRAM_OE_N = 0 for READ_WAIT cycles, counted by a 4-bit counter.
  - Data is captured from SRAM_DQ on the last RD_WAIT edge.
  - RD_DONE: Data_to_CPU = captured value and Mem_Ready = 1 for exactly one cycle.
  - Latency: Mem_Ready is high READ_WAIT+1 cycles after the sample edge.
- SRAM write path, IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> IDLE:
  - WR_SETUP (1 cycle): CE low, WE high, DQ driven.
  - WR_PULSE (WRITE_PULSE cycles): WE low.
  - WR_HOLD (1 cycle): WE high, DQ still driven, Mem_Ready = 1.
  - SRAM_DQ is driven only in WR_SETUP, WR_PULSE and WR_HOLD. It is Z in every other state.
- I/O read (latched address == IO_ADDR): IDLE -> IO_DONE.
  - Data_to_CPU = synchronized Switches and Mem_Ready = 1.
  - No SRAM strobes are asserted.
  - Latency is 1 cycle.
- I/O write: IDLE -> IO_DONE.
  - HEX_Data <= latched data, with byte enables honoured: a byte whose enable is high keeps its old value.
  - Mem_Ready = 1. No SRAM strobes.
- Byte enables: SRAM_UB_N and SRAM_LB_N follow the latched UB/LB during SRAM states and are 1 in IDLE.
- Data_to_CPU holding: holds its value from completion until the next read completes. Writes never alter it.
- Strobe withdrawn mid-access: the access runs to completion and Mem_Ready still pulses. A write is never truncated.
- Reset mid-access: all SRAM strobes return to 1 and DQ to Z at once (asynchronously). The partially written word is undefined.

Decomposition:
- Shared package mem_bridge_pkg holds:
  - the state enum {IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, IO_DONE};
  - the IO_ADDR default;
  - a 4-bit wait-counter typedef.
- One sub-module, sync_2ff: a parameterised-width two-flop synchronizer for Switches, reset to 0 by Reset_n.

Test Plan:
- Reset and idle:
  - Stimulus: release Reset_n with no strobes, then wait 10 cycles.
  - Required: all SRAM_*_N = 1, DQ = Z, Mem_Ready never high, HEX_Data = 16'h0000.
- SRAM read:
  - Stimulus: SRAM model returns 16'hBEEF at 20'h00010; MAR = 20'h00010, Mem_CE = 0, Mem_OE = 0 held 4 cycles.
  - Required: SRAM_OE_N low for exactly 2 cycles, Mem_Ready pulses once at cycle 3, Data_to_CPU = 16'hBEEF, only one access.
- SRAM write, then read back:
  - Stimulus: write 16'h1234 to 20'h00020 with UB = 0, LB = 0, then read 20'h00020.
  - Required: WE_N low for 2 cycles with DQ stable across setup and hold, then read returns 16'h1234.
- I/O:
  - Stimulus: Switches = 16'h00A5; read IO_ADDR; then write 16'hC0DE to IO_ADDR with LB = 1.
  - Required: Data_to_CPU = 16'h00A5 after 1 cycle and no SRAM strobes; HEX_Data = 16'hC000.
- Simultaneous strobes and re-arm:
  - Stimulus: Mem_OE = 0 and Mem_WE = 0 together at 20'h00030 with data 16'h5555, held 8 cycles.
  - Required: exactly one write and no read; a second access occurs only after the strobes return high.
- Reset mid-write:
  - Stimulus: deassert Reset_n during WR_PULSE.
  - Required: SRAM_WE_N = 1 and DQ = Z in the same cycle, no Mem_Ready, state = IDLE after release.
